// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg: shared definitions for the direct-mapped write-back data cache.
//   - state_e           : refill/writeback controller states
//   - *_DEF constants   : default address split (8-bit address, 8 blocks, 4 B/blk)
//   - tag_width()/blk_width(): derived tag and block widths
// Optional build macro used by the cache top: DCACHE_STATS_EN.
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int ADDR_W_DEF   = 32'd8;
  localparam int INDEX_W_DEF  = 32'd3;
  localparam int OFFSET_W_DEF = 32'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_FETCH  = 2'd2,
    UPDATE     = 2'd3
  } state_e;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int blk_width(input int offset_w);
    return 32'd8 << offset_w;
  endfunction

  localparam int TAG_W_DEF = tag_width(ADDR_W_DEF, INDEX_W_DEF, OFFSET_W_DEF);
  localparam int BLK_W_DEF = blk_width(OFFSET_W_DEF);

endpackage

// File: rtl/dcache_fsm.sv
// -----------------------------------------------------------------------------
// dcache_fsm: miss controller of the data cache. Holds the state register,
// decides IDLE -> WRITE_BACK/MEM_FETCH -> UPDATE -> IDLE, drives the registered
// memory-side request and captures the returned block for the array update.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i, hit_i         CPU request present / current access hits
//   victim_dirty_i       indexed block is valid and dirty
//   req_tag_i, index_i   tag/index of the CPU address
//   victim_tag_i/blk_i   stored tag and data of the indexed block
//   mem_busywait_i       memory busy; request held until low
//   mem_readdata_i       block returned by memory
//   busy_o               controller not idle
//   update_o             UPDATE cycle: write fill_blk_o into the arrays
//   miss_start_o         IDLE -> miss transition this cycle
//   mem_*_o              memory request (registered)
// -----------------------------------------------------------------------------
module dcache_fsm
  import dcache_pkg::*;
#(
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int INDEX_W  = INDEX_W_DEF,
  parameter  int OFFSET_W = OFFSET_W_DEF,
  localparam int TAG_W    = tag_width(ADDR_W, INDEX_W, OFFSET_W),
  localparam int BLK_W    = blk_width(OFFSET_W)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   hit_i,
  input  logic                   victim_dirty_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  input  logic [TAG_W-1:0]       victim_tag_i,
  input  logic [INDEX_W-1:0]     index_i,
  input  logic [BLK_W-1:0]       victim_blk_i,
  input  logic                   mem_busywait_i,
  input  logic [BLK_W-1:0]       mem_readdata_i,
  output logic                   busy_o,
  output logic                   update_o,
  output logic                   miss_start_o,
  output logic [BLK_W-1:0]       fill_blk_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ADDR_W-OFFSET_W-1:0] mem_address_o,
  output logic [BLK_W-1:0]       mem_writedata_o
);

  state_e                      state_q, state_d;
  logic                        mem_read_q, mem_read_d;
  logic                        mem_write_q, mem_write_d;
  logic [ADDR_W-OFFSET_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]            mem_wdata_q, mem_wdata_d;
  logic [BLK_W-1:0]            fill_q;

  // Next-state decision and miss-start strobe.
  always_comb begin
    state_d      = state_q;
    miss_start_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i && !hit_i) begin
          miss_start_o = 1'b1;
          if (victim_dirty_i) begin
            state_d = WRITE_BACK;
          end else begin
            state_d = MEM_FETCH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE_BACK: begin
        if (!mem_busywait_i) begin
          state_d = MEM_FETCH;
        end else begin
          state_d = WRITE_BACK;
        end
      end
      MEM_FETCH: begin
        if (!mem_busywait_i) begin
          state_d = UPDATE;
        end else begin
          state_d = MEM_FETCH;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request for the state being entered, so the outputs come from flops.
  // The victim address/data are stable while stalled, so sampling them on
  // entry is equivalent to driving them throughout WRITE_BACK.
  always_comb begin
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      WRITE_BACK: begin
        mem_write_d = 1'b1;
        mem_addr_d  = {victim_tag_i, index_i};
        mem_wdata_d = victim_blk_i;
      end
      MEM_FETCH: begin
        mem_read_d = 1'b1;
        mem_addr_d = {req_tag_i, index_i};
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State register, registered memory request and fill-block capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == MEM_FETCH && !mem_busywait_i) begin
        fill_q <= mem_readdata_i;
      end else begin
        fill_q <= fill_q;
      end
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign update_o        = (state_q == UPDATE);
  assign fill_blk_o      = fill_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_address_o   = mem_addr_q;
  assign mem_writedata_o = mem_wdata_q;

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache between the
// CPU datapath and a block-wide data memory.
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   READ, WRITE             CPU load/store request (both high = store)
//   ADDRESS, WRITEDATA      byte address and store byte
//   READDATA                load byte (valid on a read hit)
//   BUSYWAIT                CPU stall
//   MEM_READ/MEM_WRITE      block request to memory
//   MEM_ADDRESS             block address {tag,index}
//   MEM_WRITEDATA           block written back
//   MEM_READDATA            block returned by memory
//   MEM_BUSYWAIT            memory busy
//   ACCESS_COUNT/MISS_COUNT saturating statistics, only with DCACHE_STATS_EN
// Build macro: DCACHE_STATS_EN adds the statistics counters and ports.
// -----------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int INDEX_W  = INDEX_W_DEF,
  parameter  int OFFSET_W = OFFSET_W_DEF,
  localparam int TAG_W    = tag_width(ADDR_W, INDEX_W, OFFSET_W),
  localparam int BLK_W    = blk_width(OFFSET_W)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLK_W-1:0]           MEM_WRITEDATA,
  input  logic [BLK_W-1:0]           MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                ACCESS_COUNT,
  output logic [15:0]                MISS_COUNT
`endif
);

  localparam int NBLK = 1 << INDEX_W;

  logic [BLK_W-1:0]    data_q [NBLK];
  logic [TAG_W-1:0]    tag_q  [NBLK];
  logic [NBLK-1:0]     valid_q;
  logic [NBLK-1:0]     dirty_q;

  logic [TAG_W-1:0]    tag_s;
  logic [INDEX_W-1:0]  index_s;
  logic [OFFSET_W-1:0] offset_s;
  logic [BLK_W-1:0]    blk_s;
  logic [BLK_W-1:0]    fill_s;
  logic                req_s, hit_s, busy_s, update_s, miss_start_s;
  logic                wr_hit_s, busywait_s;

  assign tag_s    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign index_s  = ADDRESS[OFFSET_W +: INDEX_W];
  assign offset_s = ADDRESS[OFFSET_W-1:0];
  assign blk_s    = data_q[index_s];

  assign req_s      = READ | WRITE;
  assign hit_s      = valid_q[index_s] & (tag_q[index_s] == tag_s);
  assign busywait_s = (req_s & ~hit_s) | busy_s;
  // A hit can only be committed while the controller is idle.
  assign wr_hit_s   = WRITE & hit_s & ~busy_s;

  assign READDATA = blk_s[{offset_s, 3'b000} +: 8];
  assign BUSYWAIT = busywait_s;

  dcache_fsm #(
    .ADDR_W   (ADDR_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) u_fsm (
    .clk_i           (CLK),
    .rst_i           (RESET),
    .req_i           (req_s),
    .hit_i           (hit_s),
    .victim_dirty_i  (valid_q[index_s] & dirty_q[index_s]),
    .req_tag_i       (tag_s),
    .victim_tag_i    (tag_q[index_s]),
    .index_i         (index_s),
    .victim_blk_i    (blk_s),
    .mem_busywait_i  (MEM_BUSYWAIT),
    .mem_readdata_i  (MEM_READDATA),
    .busy_o          (busy_s),
    .update_o        (update_s),
    .miss_start_o    (miss_start_s),
    .fill_blk_o      (fill_s),
    .mem_read_o      (MEM_READ),
    .mem_write_o     (MEM_WRITE),
    .mem_address_o   (MEM_ADDRESS),
    .mem_writedata_o (MEM_WRITEDATA)
  );

  // Valid/dirty status: cleared by reset, set by refill and by write hits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (update_s) begin
      valid_q[index_s] <= 1'b1;
      dirty_q[index_s] <= 1'b0;
    end else if (wr_hit_s) begin
      dirty_q[index_s] <= 1'b1;
    end else begin
      valid_q <= valid_q;
      dirty_q <= dirty_q;
    end
  end

  // Data and tag arrays: not reset, validity is tracked by valid_q.
  always_ff @(posedge CLK) begin
    if (update_s) begin
      data_q[index_s] <= fill_s;
      tag_q[index_s]  <= tag_s;
    end else if (wr_hit_s) begin
      data_q[index_s][{offset_s, 3'b000} +: 8] <= WRITEDATA;
    end else begin
      tag_q[index_s] <= tag_q[index_s];
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] access_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating access and miss statistics.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      access_cnt_q <= 16'd0;
      miss_cnt_q   <= 16'd0;
    end else begin
      if (req_s && !busywait_s && access_cnt_q != 16'hFFFF) begin
        access_cnt_q <= access_cnt_q + 16'd1;
      end else begin
        access_cnt_q <= access_cnt_q;
      end
      if (miss_start_s && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q;
      end
    end
  end

  assign ACCESS_COUNT = access_cnt_q;
  assign MISS_COUNT   = miss_cnt_q;
`endif

endmodule
